// File: rtl/acp_dma_pkg.sv
// rtl/acp_dma_pkg.sv - shared types and constants for the ACP DMA writer
// Purpose: FSM state encoding, AXI burst/response codes, 4KB boundary constant
//          and a beat-size helper used by acp_dma_writer and rr_arbiter.
// Ports:   none (package)
package acp_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_AW,
    ST_W,
    ST_B,
    ST_FIN
  } dma_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         BOUNDARY_4K    = 4096;

  // log2 of the bytes per beat, i.e. the AWSIZE encoding
  function automatic int beat_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/acp_dma_writer_rr_arbiter.sv
// rtl/acp_dma_writer_rr_arbiter.sv - round-robin channel arbiter
// Purpose: picks the first requesting channel at or after the rotating pointer.
// Ports:   clk, rst_n           clock, synchronous active-low reset
//          req[NUM_CH]          per-channel request
//          en                   advance pointer past the current grant
//          grant[NUM_CH]        one-hot grant (combinational)
//          grant_idx, grant_any encoded grant and "some request present"
module rr_arbiter
  import acp_dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_any
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset back toward the pointer so the last hit,
  // which overrides earlier ones, is the channel nearest the pointer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_CH);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en && grant_any) begin
      ptr <= (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/acp_dma_writer.sv
// rtl/acp_dma_writer.sv - multi-channel stream-to-memory ACP write engine
// Purpose: arbitrates NUM_CH command/stream channels and issues 4KB-safe INCR
//          write bursts on a 64/32-bit AXI master, one command at a time.
// Ports:   clk, rst_n                          clock, synchronous active-low reset
//          cmd_valid/cmd_ready/cmd_addr/cmd_beats  per-channel command
//          s_tdata/s_tvalid/s_tready            per-channel write stream
//          M_AXI_AW*/M_AXI_W*/M_AXI_B*          AXI write master
//          done, irq                            1-cycle completion pulses
//          err                                  sticky per-channel write error
module acp_dma_writer
  import acp_dma_pkg::*;
#(
  parameter int         NUM_CH      = 4,
  parameter int         DATA_W      = 64,
  parameter int         MAX_BURST   = 16,
  parameter logic [3:0] AWCACHE_VAL = 4'b1111,
  parameter logic [4:0] AWUSER_VAL  = 5'b00001
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        cmd_valid,
  output logic [NUM_CH-1:0]        cmd_ready,
  input  logic [NUM_CH*32-1:0]     cmd_addr,
  input  logic [NUM_CH*16-1:0]     cmd_beats,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH-1:0]        s_tvalid,
  output logic [NUM_CH-1:0]        s_tready,
  output logic [31:0]              M_AXI_AWADDR,
  output logic [7:0]               M_AXI_AWLEN,
  output logic [2:0]               M_AXI_AWSIZE,
  output logic [1:0]               M_AXI_AWBURST,
  output logic [3:0]               M_AXI_AWCACHE,
  output logic [4:0]               M_AXI_AWUSER,
  output logic [2:0]               M_AXI_AWPROT,
  output logic                     M_AXI_AWVALID,
  input  logic                     M_AXI_AWREADY,
  output logic [DATA_W-1:0]        M_AXI_WDATA,
  output logic [DATA_W/8-1:0]      M_AXI_WSTRB,
  output logic                     M_AXI_WLAST,
  output logic                     M_AXI_WVALID,
  input  logic                     M_AXI_WREADY,
  input  logic [1:0]               M_AXI_BRESP,
  input  logic                     M_AXI_BVALID,
  output logic                     M_AXI_BREADY,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH-1:0]        err,
  output logic                     irq
);

  localparam int                SHIFT  = beat_shift(DATA_W);
  localparam int                IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

  dma_state_t         state;
  logic [IDX_W-1:0]   ch_q;
  logic [31:0]        addr_q;
  logic [15:0]        remaining;
  logic [8:0]         cur_len;
  logic [8:0]         beat_cnt;
  logic               awvalid_q;
  logic               bready_q;
  logic [NUM_CH-1:0]  done_q;
  logic [NUM_CH-1:0]  err_q;
  logic               irq_q;

  logic [31:0]        addr_arr  [NUM_CH];
  logic [15:0]        beats_arr [NUM_CH];
  logic [DATA_W-1:0]  tdata_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign addr_arr[g]  = cmd_addr[32*g +: 32];
    assign beats_arr[g] = cmd_beats[16*g +: 16];
    assign tdata_arr[g] = s_tdata[DATA_W*g +: DATA_W];
  end

  logic [NUM_CH-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (cmd_valid),
    .en        (state == ST_ARB),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Burst length: smallest of beats left, MAX_BURST and beats up to the next
  // 4KB page. addr_q and remaining only move on a B handshake, so this stays
  // stable for the whole AW phase.
  logic [12:0] bytes_to_4k;
  logic [12:0] beats_to_4k;
  logic [16:0] len_c;

  assign bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, addr_q[11:0]};
  assign beats_to_4k = bytes_to_4k >> SHIFT;

  always_comb begin
    len_c = {1'b0, remaining};
    if (len_c > 17'(MAX_BURST)) len_c = 17'(MAX_BURST);
    if (len_c > {4'b0, beats_to_4k}) len_c = {4'b0, beats_to_4k};
  end

  logic in_w;
  assign in_w = (state == ST_W);

  assign cmd_ready     = (state == ST_ARB) ? grant : '0;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = 8'(len_c - 17'd1);
  assign M_AXI_AWSIZE  = 3'(SHIFT);
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWCACHE = AWCACHE_VAL;
  assign M_AXI_AWUSER  = AWUSER_VAL;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;

  assign M_AXI_WDATA   = tdata_arr[ch_q];
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = in_w & s_tvalid[ch_q];
  assign M_AXI_WLAST   = in_w && (beat_cnt == cur_len - 9'd1);

  assign M_AXI_BREADY  = bready_q;
  assign done          = done_q;
  assign err           = err_q;
  assign irq           = irq_q;

  always_comb begin
    s_tready = '0;
    if (in_w) s_tready[ch_q] = M_AXI_WREADY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ch_q      <= '0;
      addr_q    <= '0;
      remaining <= '0;
      cur_len   <= '0;
      beat_cnt  <= '0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= '0;
      err_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      done_q <= '0;
      irq_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|cmd_valid) state <= ST_ARB;
        end
        ST_ARB: begin
          // The request may have been withdrawn since IDLE; then just go back.
          if (grant_any) begin
            ch_q             <= grant_idx;
            addr_q           <= addr_arr[grant_idx] & ~32'(DATA_W/8 - 1);
            remaining        <= beats_arr[grant_idx];
            err_q[grant_idx] <= 1'b0;
            if (beats_arr[grant_idx] == 16'd0) begin
              state  <= ST_FIN;
              done_q <= grant;
              irq_q  <= 1'b1;
            end else begin
              state     <= ST_AW;
              awvalid_q <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_AW: begin
          if (M_AXI_AWREADY) begin
            awvalid_q <= 1'b0;
            cur_len   <= 9'(len_c);
            beat_cnt  <= '0;
            state     <= ST_W;
          end
        end
        ST_W: begin
          if (M_AXI_WVALID && M_AXI_WREADY) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (M_AXI_WLAST) begin
              state    <= ST_B;
              bready_q <= 1'b1;
            end
          end
        end
        ST_B: begin
          if (M_AXI_BVALID) begin
            bready_q  <= 1'b0;
            addr_q    <= addr_q + (32'(cur_len) << SHIFT);
            remaining <= remaining - {7'b0, cur_len};
            if (M_AXI_BRESP != AXI_RESP_OKAY) begin
              err_q[ch_q] <= 1'b1;
              state       <= ST_FIN;
              done_q      <= CH_ONE << ch_q;
              irq_q       <= 1'b1;
            end else if (remaining == {7'b0, cur_len}) begin
              state  <= ST_FIN;
              done_q <= CH_ONE << ch_q;
              irq_q  <= 1'b1;
            end else begin
              state     <= ST_AW;
              awvalid_q <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acp_dma_writer.sv
// tb/tb_acp_dma_writer.sv - directed self-checking bench for acp_dma_writer
module tb_acp_dma_writer;

  localparam int NCH = 4;
  localparam int DW  = 64;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic [NCH-1:0]    cmd_valid = '0;
  logic [NCH-1:0]    cmd_ready;
  logic [NCH*32-1:0] cmd_addr  = '0;
  logic [NCH*16-1:0] cmd_beats = '0;
  logic [NCH*DW-1:0] s_tdata   = '0;
  logic [NCH-1:0]    s_tvalid  = '0;
  logic [NCH-1:0]    s_tready;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [3:0]        awcache;
  logic [4:0]        awuser;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready   = 1'b0;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready    = 1'b0;
  logic [1:0]        bresp     = 2'b00;
  logic              bvalid    = 1'b0;
  logic              bready;
  logic [NCH-1:0]    done;
  logic [NCH-1:0]    err;
  logic              irq;

  always #5 clk = ~clk;

  acp_dma_writer #(
    .NUM_CH    (NCH),
    .DATA_W    (DW),
    .MAX_BURST (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_beats     (cmd_beats),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWLEN   (awlen),
    .M_AXI_AWSIZE  (awsize),
    .M_AXI_AWBURST (awburst),
    .M_AXI_AWCACHE (awcache),
    .M_AXI_AWUSER  (awuser),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WLAST   (wlast),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .done          (done),
    .err           (err),
    .irq           (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave / source model state
  bit          stall     = 1'b0;
  int          err_burst = -1;
  int          b_idx     = 0;
  int          pending_b = 0;
  bit          b_hs      = 1'b0;
  bit          aw_wait   = 1'b0;
  logic [NCH-1:0] req_pending = '0;
  logic [31:0] req_addr  [NCH];
  logic [15:0] req_beats [NCH];
  int          src_cnt   [NCH];
  int          done_cnt  [NCH];
  logic [31:0] aw_addr_q [$];
  logic [7:0]  aw_len_q  [$];
  int          grant_q   [$];
  int          irq_cnt   = 0;
  int          awv_cycles = 0;
  int          w_hs      = 0;
  int          w_beat    = 0;
  int          c_hit;
  logic [7:0]  cur_awlen = '0;

  initial begin
    for (int c = 0; c < NCH; c++) begin
      req_addr[c]  = '0;
      req_beats[c] = '0;
      src_cnt[c]   = 0;
      done_cnt[c]  = 0;
    end
  end

  // Inputs change on the falling edge; handshakes are evaluated 1ns later,
  // when everything the next rising edge will see has settled.
  always @(negedge clk) begin
    if (b_hs) begin
      bvalid = 1'b0;
      b_hs   = 1'b0;
    end
    for (int c = 0; c < NCH; c++) begin
      cmd_valid[c]          = req_pending[c];
      cmd_addr[c*32 +: 32]  = req_addr[c];
      cmd_beats[c*16 +: 16] = req_beats[c];
      s_tvalid[c]           = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      s_tdata[c*DW +: DW]   = {32'(c), 32'(src_cnt[c])};
    end
    awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!rst_n) bvalid = 1'b0;
    else if (!bvalid && pending_b > 0 && (!stall || $urandom_range(0, 1) == 1)) bvalid = 1'b1;
    bresp = (b_idx == err_burst) ? 2'b10 : 2'b00;
    #1;
    if (!rst_n) begin
      pending_b = 0;
      aw_wait   = 1'b0;
    end else begin
      if (aw_wait) check("aw_hold", 64'(awvalid), 64'd1);
      if (awvalid) awv_cycles++;
      if (awvalid && awready) begin
        aw_addr_q.push_back(awaddr);
        aw_len_q.push_back(awlen);
        check("aw_fixed", 64'({awsize, awburst, awcache, awuser, awprot}),
              64'({3'd3, 2'b01, 4'b1111, 5'b00001, 3'd0}));
        cur_awlen = awlen;
        w_beat    = 0;
      end
      aw_wait = awvalid && !awready;
      if (wvalid && wready) begin
        c_hit = -1;
        for (int c = 0; c < NCH; c++) if (s_tready[c]) c_hit = c;
        check("w_sel", 64'(c_hit >= 0), 64'd1);
        if (c_hit >= 0) begin
          check("wdata", wdata, {32'(c_hit), 32'(src_cnt[c_hit])});
          src_cnt[c_hit]++;
        end
        check("wlast", 64'(wlast), 64'(w_beat == int'(cur_awlen)));
        check("wstrb", 64'(wstrb), 64'hff);
        w_beat++;
        w_hs++;
        if (wlast) pending_b++;
      end
      if (bvalid && bready) begin
        pending_b--;
        b_idx++;
        b_hs = 1'b1;
      end
      for (int c = 0; c < NCH; c++) begin
        if (cmd_valid[c] && cmd_ready[c]) begin
          grant_q.push_back(c);
          req_pending[c] = 1'b0;
        end
        if (done[c]) done_cnt[c]++;
      end
      if (irq || done != '0) begin
        check("irq_with_done", 64'(irq), 64'(done != '0));
        if (irq) irq_cnt++;
      end
    end
  end

  task automatic post(input int c, input logic [31:0] a, input logic [15:0] b);
    req_addr[c]    = a;
    req_beats[c]   = b;
    req_pending[c] = 1'b1;
  endtask

  task automatic clear_logs();
    aw_addr_q.delete();
    aw_len_q.delete();
    grant_q.delete();
    for (int c = 0; c < NCH; c++) done_cnt[c] = 0;
    irq_cnt    = 0;
    awv_cycles = 0;
    b_idx      = 0;
  endtask

  task automatic wait_done(input int c, input int n);
    int t = 0;
    while (done_cnt[c] < n && t < 3000) begin
      @(negedge clk);
      #2;
      t++;
    end
    check($sformatf("done_ch%0d", c), 64'(done_cnt[c]), 64'(n));
  endtask

  task automatic check_aw(input int i, input logic [31:0] a, input logic [7:0] l);
    if (i < aw_addr_q.size()) begin
      check($sformatf("aw%0d_addr", i), 64'(aw_addr_q[i]), 64'(a));
      check($sformatf("aw%0d_len", i), 64'(aw_len_q[i]), 64'(l));
    end else begin
      check($sformatf("aw%0d_present", i), 64'(aw_addr_q.size()), 64'(i + 1));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, 64'({awvalid, wvalid, bready, cmd_ready, s_tready, done, err, irq}), 64'd0);
  endtask

  initial begin
    int base;
    int t;
    repeat (3) @(negedge clk);
    #2;
    check_idle_outputs("reset_state_in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check_idle_outputs("reset_state_released");

    // 1: 40 beats from 0x1000 -> 16+16+8
    clear_logs();
    post(0, 32'h1000, 16'd40);
    wait_done(0, 1);
    check("t1_aw_count", 64'(aw_addr_q.size()), 64'd3);
    check_aw(0, 32'h1000, 8'd15);
    check_aw(1, 32'h1080, 8'd15);
    check_aw(2, 32'h1100, 8'd7);
    check("t1_irq_count", 64'(irq_cnt), 64'd1);

    // 2: 4KB split, 0x1FE0 leaves 4 beats before 0x2000
    clear_logs();
    post(0, 32'h1FE0, 16'd16);
    wait_done(0, 1);
    check("t2_aw_count", 64'(aw_addr_q.size()), 64'd2);
    check_aw(0, 32'h1FE0, 8'd3);
    check_aw(1, 32'h2000, 8'd11);

    // 3: round robin from a fresh pointer
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    for (int c = 0; c < NCH; c++) post(c, 32'h8000 + 32'(c) * 32'h100, 16'd4);
    for (int c = 0; c < NCH; c++) wait_done(c, 1);
    post(0, 32'h8800, 16'd4);
    post(2, 32'h8A00, 16'd4);
    wait_done(0, 2);
    wait_done(2, 2);
    check("t3_grant_count", 64'(grant_q.size()), 64'd6);
    if (grant_q.size() == 6) begin
      check("t3_g0", 64'(grant_q[0]), 64'd0);
      check("t3_g1", 64'(grant_q[1]), 64'd1);
      check("t3_g2", 64'(grant_q[2]), 64'd2);
      check("t3_g3", 64'(grant_q[3]), 64'd3);
      check("t3_g4", 64'(grant_q[4]), 64'd0);
      check("t3_g5", 64'(grant_q[5]), 64'd2);
    end
    check("t3_aw_count", 64'(aw_addr_q.size()), 64'd6);
    check_aw(0, 32'h8000, 8'd3);
    check_aw(3, 32'h8300, 8'd3);

    // 4: zero-length command
    clear_logs();
    post(1, 32'h9000, 16'd0);
    wait_done(1, 1);
    check("t4_grant_count", 64'(grant_q.size()), 64'd1);
    check("t4_awvalid_cycles", 64'(awv_cycles), 64'd0);
    check("t4_irq_count", 64'(irq_cnt), 64'd1);

    // 5: SLVERR on 2nd of 3 bursts
    clear_logs();
    err_burst = 1;
    post(2, 32'h3000, 16'd40);
    wait_done(2, 1);
    check("t5_aw_count", 64'(aw_addr_q.size()), 64'd2);
    check("t5_err_set", 64'(err), 64'b0100);
    @(negedge clk);
    #2;
    check("t5_err_sticky", 64'(err), 64'b0100);
    err_burst = -1;
    clear_logs();
    post(2, 32'h3400, 16'd4);
    wait_done(2, 1);
    check("t5_err_cleared", 64'(err), 64'd0);

    // 6: random stalls, then reset mid-W
    stall = 1'b1;
    clear_logs();
    post(3, 32'h4000, 16'd20);
    wait_done(3, 1);
    check("t6_aw_count", 64'(aw_addr_q.size()), 64'd2);
    check_aw(0, 32'h4000, 8'd15);
    check_aw(1, 32'h4080, 8'd3);
    post(1, 32'h5000, 16'd32);
    base = w_hs;
    t    = 0;
    while (w_hs < base + 5 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("t6_mid_w_reached", 64'(w_hs >= base + 5), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    check_idle_outputs("t6_reset_mid_w");
    rst_n = 1'b1;
    stall = 1'b0;
    clear_logs();
    post(0, 32'h6007, 16'd8);
    wait_done(0, 1);
    check("t6_recover_aw_count", 64'(aw_addr_q.size()), 64'd1);
    check_aw(0, 32'h6000, 8'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
